// File: rtl/tick_sequencer.sv
// One-hot phase sequencer for the control unit: walks tick0..tick[len] once per
// instruction, with stall, synchronous clear, one-shot or auto-restart, and a done strobe.
module tick_sequencer #(
  parameter int NUM_TICKS    = 4,
  parameter bit AUTO_RESTART = 1'b1,
  parameter int IDX_W        = $clog2(NUM_TICKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 start,
  input  logic [IDX_W-1:0]     len,
  output logic [NUM_TICKS-1:0] tick,
  output logic [IDX_W-1:0]     tick_idx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_TICKS - 1);
  localparam logic [IDX_W-1:0]     IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [NUM_TICKS-1:0] TICK0    = NUM_TICKS'(1);
  localparam logic [NUM_TICKS-1:0] TICK_OFF = {NUM_TICKS{1'b0}};
  // State entered after reset, clear, or completion of an op.
  localparam state_t               REST_ST  = AUTO_RESTART ? ST_RUN : ST_IDLE;
  localparam logic [NUM_TICKS-1:0] RST_TICK = AUTO_RESTART ? TICK0 : TICK_OFF;

  function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] l);
    if (l > LAST_IDX) begin
      return LAST_IDX;
    end else begin
      return l;
    end
  endfunction

  function automatic logic [NUM_TICKS-1:0] decode_tick(input logic run, input logic [IDX_W-1:0] idx);
    if (run) begin
      return TICK0 << idx;
    end else begin
      return TICK_OFF;
    end
  endfunction

  state_t                 state_r, state_nx_s;
  logic [IDX_W-1:0]       idx_r, idx_nx_s;
  logic [IDX_W-1:0]       len_q_r, len_nx_s;
  logic [NUM_TICKS-1:0]   tick_r, tick_nx_s;
  logic [IDX_W-1:0]       len_cl_s;
  logic [IDX_W-1:0]       eff_len_s;
  logic                   last_s;
  logic                   adv_s;

  // Tick0 reads the live length; later ticks use the value captured when tick0 advanced.
  always_comb begin
    len_cl_s  = clamp_len(len);
    eff_len_s = (idx_r == IDX_ZERO) ? len_cl_s : len_q_r;
    last_s    = (idx_r == eff_len_s);
    adv_s     = (state_r == ST_RUN) & en & ~clr;
  end

  // Next-state logic: clear first, then start from idle, then advance/wrap.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    len_nx_s   = len_q_r;
    if (clr) begin
      state_nx_s = REST_ST;
      idx_nx_s   = IDX_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !AUTO_RESTART) begin
            state_nx_s = ST_RUN;
            idx_nx_s   = IDX_ZERO;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (en) begin
            if (idx_r == IDX_ZERO) begin
              len_nx_s = len_cl_s;
            end else begin
              len_nx_s = len_q_r;
            end
            if (last_s) begin
              state_nx_s = REST_ST;
              idx_nx_s   = IDX_ZERO;
            end else begin
              idx_nx_s   = idx_r + IDX_W'(1);
            end
          end else begin
            state_nx_s = ST_RUN;
          end
        end
        default: begin
          state_nx_s = REST_ST;
          idx_nx_s   = IDX_ZERO;
        end
      endcase
    end
    tick_nx_s = decode_tick(state_nx_s == ST_RUN, idx_nx_s);
  end

  // State, captured length and pre-decoded one-hot tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= REST_ST;
      idx_r   <= IDX_ZERO;
      len_q_r <= LAST_IDX;
      tick_r  <= RST_TICK;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      len_q_r <= len_nx_s;
      tick_r  <= tick_nx_s;
    end
  end

  assign tick     = tick_r;
  assign tick_idx = idx_r;
  assign busy     = (state_r == ST_RUN);
  // Gated by rst so no strobe escapes while reset is held.
  assign done     = rst & adv_s & last_s;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: directed vectors checked through a scoreboard queue,
// then a random phase with per-cycle invariant and op-length checks.
module tb_tick_sequencer;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_on  = 1'b0;

  // A: 4 ticks auto, B: 8 ticks one-shot, C: 5 ticks auto, D: 5 ticks one-shot
  logic       a_rst, a_en, a_clr, a_start;
  logic [1:0] a_len, a_idx;
  logic [3:0] a_tick;
  logic       a_busy, a_done;
  logic       b_rst, b_en, b_clr, b_start;
  logic [2:0] b_len, b_idx;
  logic [7:0] b_tick;
  logic       b_busy, b_done;
  logic       c_rst, c_en, c_clr, c_start;
  logic [2:0] c_len, c_idx;
  logic [4:0] c_tick;
  logic       c_busy, c_done;
  logic       d_rst, d_en, d_clr, d_start;
  logic [2:0] d_len, d_idx;
  logic [4:0] d_tick;
  logic       d_busy, d_done;

  tick_sequencer #(.NUM_TICKS(4), .AUTO_RESTART(1'b1)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .clr(a_clr), .start(a_start), .len(a_len),
    .tick(a_tick), .tick_idx(a_idx), .busy(a_busy), .done(a_done));
  tick_sequencer #(.NUM_TICKS(8), .AUTO_RESTART(1'b0)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .clr(b_clr), .start(b_start), .len(b_len),
    .tick(b_tick), .tick_idx(b_idx), .busy(b_busy), .done(b_done));
  tick_sequencer #(.NUM_TICKS(5), .AUTO_RESTART(1'b1)) dut_c (
    .clk(clk), .rst(c_rst), .en(c_en), .clr(c_clr), .start(c_start), .len(c_len),
    .tick(c_tick), .tick_idx(c_idx), .busy(c_busy), .done(c_done));
  tick_sequencer #(.NUM_TICKS(5), .AUTO_RESTART(1'b0)) dut_d (
    .clk(clk), .rst(d_rst), .en(d_en), .clr(d_clr), .start(d_start), .len(d_len),
    .tick(d_tick), .tick_idx(d_idx), .busy(d_busy), .done(d_done));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         dut;
    logic [7:0] tick;
    logic       done;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outputs expected for it.
  task automatic step(input int dut, input bit r, input bit e, input bit c, input bit s,
                      input int ln, input logic [7:0] etick, input bit edone, input string nm);
    exp_t x;
    @(negedge clk);
    case (dut)
      0: begin a_rst = r; a_en = e; a_clr = c; a_start = s; a_len = 2'(ln); end
      1: begin b_rst = r; b_en = e; b_clr = c; b_start = s; b_len = 3'(ln); end
      default: begin c_rst = r; c_en = e; c_clr = c; c_start = s; c_len = 3'(ln); end
    endcase
    x.dut = dut; x.tick = etick; x.done = edone; x.name = nm;
    sb_q.push_back(x);
  endtask

  // Scoreboard monitor: compares each queued expectation against the addressed DUT.
  exp_t       m_e;
  logic [7:0] m_tick;
  logic [2:0] m_idx, m_eidx;
  logic       m_busy, m_done;
  always @(negedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      case (m_e.dut)
        0: begin m_tick = {4'b0, a_tick}; m_idx = {1'b0, a_idx}; m_busy = a_busy; m_done = a_done; end
        1: begin m_tick = b_tick; m_idx = b_idx; m_busy = b_busy; m_done = b_done; end
        default: begin m_tick = {3'b0, c_tick}; m_idx = c_idx; m_busy = c_busy; m_done = c_done; end
      endcase
      m_eidx = 3'd0;
      for (int i = 0; i < 8; i++) begin
        if (m_e.tick[i]) m_eidx = 3'(i);
      end
      check({m_e.name, "_tick"}, m_tick, m_e.tick);
      check({m_e.name, "_idx"}, m_idx, m_eidx);
      check({m_e.name, "_busy"}, m_busy, |m_e.tick);
      check({m_e.name, "_done"}, m_done, m_e.done);
    end
  end

  // Random-phase reference state, one slot per DUT (0 = C auto, 1 = D one-shot).
  int   op_last[2], op_cnt[2];
  bit   op_ok[2], nxt_ok[2], nxt_busy[2];
  int   nxt_idx[2];

  task automatic inv(input int d, input logic [4:0] tk, input logic [2:0] ix, input logic bz,
                     input logic dn, input logic e, input logic c, input logic s,
                     input logic [2:0] ln, input bit auto_m);
    check("inv_onehot0", 32'($onehot0(tk)), 32'd1);
    check("inv_idx_range", 32'(ix < 3'd5), 32'd1);
    check("inv_tick_decode", tk, bz ? (5'b1 << ix) : 5'b0);
    if (nxt_ok[d]) begin
      check("inv_next_busy", bz, nxt_busy[d]);
      check("inv_next_idx", ix, nxt_idx[d]);
    end
    nxt_ok[d] = 1'b1;
    if (c) begin
      check("inv_done_clr", dn, 1'b0);
      nxt_busy[d] = auto_m; nxt_idx[d] = 0;
    end else if (!bz) begin
      check("inv_done_idle", dn, 1'b0);
      nxt_busy[d] = s; nxt_idx[d] = 0;
    end else if (!e) begin
      check("inv_done_stall", dn, 1'b0);
      nxt_busy[d] = 1'b1; nxt_idx[d] = int'(ix);
    end else begin
      if (ix == 3'd0) begin
        op_last[d] = (ln > 3'd4) ? 4 : int'(ln);
        op_cnt[d]  = 0;
        op_ok[d]   = 1'b1;
      end
      op_cnt[d]++;
      if (op_ok[d]) begin
        check("inv_op_len_done", dn, op_cnt[d] == op_last[d] + 1);
        check("inv_op_idx", ix, op_cnt[d] - 1);
      end
      if (dn) begin
        nxt_busy[d] = auto_m; nxt_idx[d] = 0;
      end else begin
        nxt_busy[d] = 1'b1; nxt_idx[d] = int'(ix) + 1;
      end
    end
  endtask

  // Invariant monitor for the random phase.
  always @(negedge clk) begin
    #2;
    if (rand_on) begin
      inv(0, c_tick, c_idx, c_busy, c_done, c_en, c_clr, c_start, c_len, 1'b1);
      inv(1, d_tick, d_idx, d_busy, d_done, d_en, d_clr, d_start, d_len, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1'b0; a_en = 1'b0; a_clr = 1'b0; a_start = 1'b0; a_len = 2'd3;
    b_rst = 1'b0; b_en = 1'b0; b_clr = 1'b0; b_start = 1'b0; b_len = 3'd2;
    c_rst = 1'b0; c_en = 1'b0; c_clr = 1'b0; c_start = 1'b0; c_len = 3'd0;
    d_rst = 1'b0; d_en = 1'b0; d_clr = 1'b0; d_start = 1'b0; d_len = 3'd0;
    for (int i = 0; i < 2; i++) begin
      op_last[i] = 0; op_cnt[i] = 0; op_ok[i] = 1'b0;
      nxt_ok[i] = 1'b0; nxt_busy[i] = 1'b0; nxt_idx[i] = 0;
    end

    // A: 4 ticks auto-restart, len=3
    step(0, 0, 1, 0, 0, 3, 8'h01, 0, "a_reset");
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 1, 0, 0, 3, 8'(1 << (i % 4)), (i % 4) == 3, "a_seq");
    end
    step(0, 1, 1, 0, 0, 3, 8'h02, 0, "a_seq");
    step(0, 1, 1, 0, 0, 3, 8'h04, 0, "a_seq");
    step(0, 1, 1, 0, 0, 3, 8'h08, 1, "a_wrap");
    step(0, 1, 1, 0, 0, 1, 8'h01, 0, "a_len1_t0");
    step(0, 1, 1, 0, 0, 3, 8'h02, 1, "a_len_mid");
    step(0, 1, 1, 0, 0, 3, 8'h01, 0, "a_len_resample");
    step(0, 1, 1, 0, 0, 3, 8'h02, 0, "a_full");
    step(0, 1, 1, 0, 0, 3, 8'h04, 0, "a_full");
    step(0, 1, 1, 0, 0, 3, 8'h08, 1, "a_full");
    step(0, 1, 1, 0, 0, 3, 8'h01, 0, "a_pre_stall");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 3, 8'h02, 0, "a_stall");
    step(0, 1, 1, 0, 0, 3, 8'h02, 0, "a_unstall");
    step(0, 1, 1, 1, 0, 3, 8'h04, 0, "a_clr_t2");
    step(0, 1, 1, 0, 0, 3, 8'h01, 0, "a_after_clr");
    step(0, 1, 1, 0, 0, 3, 8'h02, 0, "a_seq2");
    step(0, 1, 1, 0, 0, 3, 8'h04, 0, "a_seq2");
    step(0, 1, 1, 1, 0, 3, 8'h08, 0, "a_clr_last");
    step(0, 1, 1, 0, 0, 0, 8'h01, 1, "a_len0");
    step(0, 1, 1, 0, 0, 0, 8'h01, 1, "a_len0_rep");
    step(0, 1, 1, 0, 0, 3, 8'h01, 0, "a_len3_t0");
    step(0, 1, 1, 0, 0, 3, 8'h02, 0, "a_seq3");
    step(0, 1, 0, 0, 0, 3, 8'h04, 0, "a_pre_rst");
    step(0, 0, 0, 0, 0, 3, 8'h01, 0, "a_async_rst");
    step(0, 0, 1, 0, 0, 3, 8'h01, 0, "a_rst_hold");
    step(0, 1, 1, 0, 0, 3, 8'h01, 0, "a_resume");
    step(0, 1, 1, 0, 0, 3, 8'h02, 0, "a_resume2");

    // B: 8 ticks one-shot, len=2
    step(1, 0, 0, 0, 0, 2, 8'h00, 0, "b_reset");
    step(1, 1, 0, 0, 0, 2, 8'h00, 0, "b_idle");
    step(1, 1, 0, 0, 1, 2, 8'h00, 0, "b_start");
    step(1, 1, 1, 0, 0, 2, 8'h01, 0, "b_t0");
    step(1, 1, 1, 0, 1, 2, 8'h02, 0, "b_start_busy");
    step(1, 1, 1, 0, 0, 2, 8'h04, 1, "b_done");
    step(1, 1, 1, 0, 0, 2, 8'h00, 0, "b_idle2");
    step(1, 1, 1, 0, 1, 2, 8'h00, 0, "b_start2");
    step(1, 1, 1, 0, 0, 2, 8'h01, 0, "b_t0_2");
    step(1, 1, 1, 0, 0, 2, 8'h02, 0, "b_t1_2");
    step(1, 1, 1, 0, 1, 2, 8'h04, 1, "b_done_start");
    step(1, 1, 1, 0, 0, 2, 8'h00, 0, "b_not_honoured");
    step(1, 1, 0, 0, 1, 2, 8'h00, 0, "b_restart_noen");
    step(1, 1, 1, 0, 0, 2, 8'h01, 0, "b_restart");
    step(1, 1, 1, 0, 0, 2, 8'h02, 0, "b_restart");
    step(1, 1, 1, 0, 0, 2, 8'h04, 1, "b_restart_done");
    step(1, 1, 1, 0, 0, 2, 8'h00, 0, "b_final_idle");

    // C: 5 ticks auto, len=7 clamps to a full 5-tick op
    step(2, 0, 1, 0, 0, 7, 8'h01, 0, "c_reset");
    step(2, 1, 1, 0, 0, 7, 8'h01, 0, "c_clamp_t0");
    step(2, 1, 1, 0, 0, 0, 8'h02, 0, "c_clamp_t1");
    step(2, 1, 1, 0, 0, 0, 8'h04, 0, "c_clamp_t2");
    step(2, 1, 1, 0, 0, 0, 8'h08, 0, "c_clamp_t3");
    step(2, 1, 1, 0, 0, 0, 8'h10, 1, "c_clamp_last");
    step(2, 1, 1, 0, 0, 0, 8'h01, 1, "c_len0");

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);

    // Random phase on C and D
    @(negedge clk);
    d_rst = 1'b1;
    @(negedge clk);
    rand_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      c_en = ($urandom_range(0, 3) != 0); c_clr = ($urandom_range(0, 15) == 0);
      c_start = ($urandom_range(0, 3) == 0); c_len = 3'($urandom_range(0, 7));
      d_en = ($urandom_range(0, 3) != 0); d_clr = ($urandom_range(0, 15) == 0);
      d_start = ($urandom_range(0, 3) == 0); d_len = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    rand_on = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
